param_bit_unstuffer: RTL
========================

// Module: param_bit_unstuffer
// PURPOSE
//   Parametrised USB receive-path bit unstuffer with stuff-error detection.
//   Removes the stuffed zero inserted after RUN_LEN consecutive ones.
//   Flags a 1 arriving in a stuff slot as a stuff error. After an error it
//   discards the rest of the packet until the packet-level clear.
//   Sits between the NRZI decoder/bit sampler and the PID/byte deserialiser.
// PARAMETERS
//   RUN_LEN    6  consecutive ones after which a stuffed 0 is expected (>=2)
//   ERR_CNT_W  8  width of saturating stuff-error counter
//   CNT_W      $clog2(RUN_LEN+1)  localparam, width of one_count
// PORTS
//   clk            in   1          system clock, all logic on rising edge
//   RST            in   1          asynchronous, active-high reset
//   in_bit         in   1          stuffed input bit (NRZI level if UNSTUFF_NRZI_EN)
//   in_valid       in   1          in_bit qualifier, one bit per asserted cycle
//   pkt_clear      in   1          sync clear at SOP/EOP: resets run/error state
//   err_count_clr  in   1          sync clear of err_count
//   out_bit        out  1          unstuffed data bit, holds when out_valid=0
//   out_valid      out  1          one-cycle pulse per data bit delivered
//   stuff_drop     out  1          one-cycle pulse: stuffed 0 removed
//   stuff_err      out  1          one-cycle pulse: 1 received in stuff slot
//   in_error       out  1          level: block in ERROR state
//   one_count      out  CNT_W      current run of consecutive data ones
//   err_count      out  ERR_CNT_W  saturating count of stuff errors
// BEHAVIOUR
//   Reset: all outputs 0; state RUN; NRZI prev level 1.
//   Outputs are registered. Latency is 1 clk from in_valid to out_valid/flags.
//   With in_valid=0, state and one_count hold; pulses are 0.
//   FSM states:
//   - RUN, valid bit 1: out_bit=1, out_valid=1, one_count+1. When the new
//     count equals RUN_LEN, go to STUFF with one_count=RUN_LEN.
//   - RUN, valid bit 0: out_bit=0, out_valid=1, one_count=0.
//   - STUFF, valid bit 0: bit dropped, out_valid=0, stuff_drop=1,
//     one_count=0, go to RUN.
//   - STUFF, valid bit 1: out_valid=0, stuff_err=1, err_count+1 (saturates
//     at all-ones), one_count=0, go to ERROR.
//   - ERROR: in_error=1; every in_valid ignored, no pulses; exit only via
//     pkt_clear or RST.
//   pkt_clear in any state (highest priority after RST): state RUN,
//     one_count=0, in_error=0. Any bit in the same cycle is discarded.
//   err_count_clr with a simultaneous stuff error: clear wins, err_count=0.
//   Flags are mutually exclusive: at most one of out_valid, stuff_drop and
//     stuff_err is high in any cycle.
//   RST asserted mid-packet (any state): immediate return to reset values.
// CONFIGURATION
//   UNSTUFF_NRZI_EN defined: in_bit is a raw NRZI line level.
//     decoded = (in_bit == prev_level); prev_level <= in_bit on each in_valid,
//     stuffed bits and ERROR-state bits included.
//     pkt_clear and RST set prev_level=1 (idle J). The FSM uses the decoded bit.
//   UNSTUFF_NRZI_EN undefined: in_bit is already decoded; no prev_level
//     register; FSM uses in_bit directly.
// TESTING
//   1 RUN_LEN=6, bits 1111110 then 1 -> six out_valid ones with one_count
//     1..6, stuff_drop on the 0, then out 1 with one_count=1.
//   2 Bits 1111111 then 0101010101 -> six ones out, one stuff_err pulse,
//     err_count=1, in_error=1, no out_valid; pkt_clear then 0 -> out 0.
//   3 Five 1s, pkt_clear, then 1111110 -> no early drop; drop only after
//     the sixth 1 following the clear.
//   4 Sixth 1, in_valid low 4 cycles, then 0 -> still dropped with
//     stuff_drop; no stray pulses during the gap.
//   5 ERR_CNT_W=2, 5 errors with pkt_clear between -> err_count 1,2,3,3,3;
//     error + err_count_clr same cycle -> err_count=0.
//   6 RST in STUFF -> outputs 0 next cycle. UNSTUFF_NRZI_EN: levels 1,1,0,0
//     from reset -> decoded 1,1,0,1.

Source files
------------

// File: rtl/param_bit_unstuffer.sv
// USB receive-path bit unstuffer with stuff-error detection and a saturating error counter.
// Optional build macro UNSTUFF_NRZI_EN: in_bit is a raw NRZI line level that is decoded here.
module param_bit_unstuffer #(
  parameter int RUN_LEN   = 6,
  parameter int ERR_CNT_W = 8,
  localparam int CNT_W    = $clog2(RUN_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 in_bit,
  input  logic                 in_valid,
  input  logic                 pkt_clear,
  input  logic                 err_count_clr,
  output logic                 out_bit,
  output logic                 out_valid,
  output logic                 stuff_drop,
  output logic                 stuff_err,
  output logic                 in_error,
  output logic [CNT_W-1:0]     one_count,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STUFF = 2'd1,
    ERROR = 2'd2
  } state_t;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  state_t               state_p1, state_p0;
  logic [CNT_W-1:0]     cnt_p1, cnt_p0, cnt_inc_p0;
  logic                 bit_p1, bit_p0;
  logic                 vld_p1, vld_p0;
  logic                 drop_p1, drop_p0;
  logic                 err_p1, err_p0;
  logic [ERR_CNT_W-1:0] errcnt_p1, errcnt_p0;
  logic                 dec_bit_p0;

`ifdef UNSTUFF_NRZI_EN
  logic prev_p1, prev_p0;

  // NRZI: no transition means 1; the level is tracked on every valid bit, stuffed or not
  assign dec_bit_p0 = (in_bit == prev_p1);

  always_comb begin
    prev_p0 = prev_p1;
    if (pkt_clear)
      prev_p0 = 1'b1;
    else if (in_valid)
      prev_p0 = in_bit;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) prev_p1 <= 1'b1;
    else     prev_p1 <= prev_p0;
  end
`else
  assign dec_bit_p0 = in_bit;
`endif

  assign cnt_inc_p0 = cnt_p1 + CNT_W'(1);

  // Stage 0: next-state and flag decode from the current bit
  always_comb begin
    state_p0  = state_p1;
    cnt_p0    = cnt_p1;
    bit_p0    = bit_p1;
    vld_p0    = 1'b0;
    drop_p0   = 1'b0;
    err_p0    = 1'b0;
    errcnt_p0 = errcnt_p1;
    if (pkt_clear) begin
      state_p0 = RUN;
      cnt_p0   = '0;
    end else if (in_valid) begin
      unique case (state_p1)
        RUN: begin
          vld_p0 = 1'b1;
          bit_p0 = dec_bit_p0;
          if (dec_bit_p0) begin
            cnt_p0 = cnt_inc_p0;
            if (cnt_inc_p0 == CNT_W'(RUN_LEN))
              state_p0 = STUFF;
          end else begin
            cnt_p0 = '0;
          end
        end
        STUFF: begin
          cnt_p0 = '0;
          if (dec_bit_p0) begin
            err_p0    = 1'b1;
            errcnt_p0 = sat_inc(errcnt_p1);
            state_p0  = ERROR;
          end else begin
            drop_p0  = 1'b1;
            state_p0 = RUN;
          end
        end
        default: ;
      endcase
    end
    if (err_count_clr)
      errcnt_p0 = '0;
  end

  // Stage 1: registered outputs
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_p1  <= RUN;
      cnt_p1    <= '0;
      bit_p1    <= 1'b0;
      vld_p1    <= 1'b0;
      drop_p1   <= 1'b0;
      err_p1    <= 1'b0;
      errcnt_p1 <= '0;
    end else begin
      state_p1  <= state_p0;
      cnt_p1    <= cnt_p0;
      bit_p1    <= bit_p0;
      vld_p1    <= vld_p0;
      drop_p1   <= drop_p0;
      err_p1    <= err_p0;
      errcnt_p1 <= errcnt_p0;
    end
  end

  assign out_bit    = bit_p1;
  assign out_valid  = vld_p1;
  assign stuff_drop = drop_p1;
  assign stuff_err  = err_p1;
  assign in_error   = (state_p1 == ERROR);
  assign one_count  = cnt_p1;
  assign err_count  = errcnt_p1;

endmodule
